// File: rtl/clk_en_seq_ctrl.sv
// Clock-enable sequencer: applies requested enable changes one channel at a time,
// round-robin, waiting a programmable settle time before acknowledging each change.
module clk_en_seq_ctrl #(
   parameter int NUM_CLK_EN = 4,
   parameter int SETTLE_W   = 8
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic [NUM_CLK_EN-1:0]                               req_en,
   input  logic [SETTLE_W-1:0]                                 settle_cycles,
   output logic [NUM_CLK_EN-1:0]                               clk_en,
   output logic [NUM_CLK_EN-1:0]                               ack,
   output logic                                                busy,
   output logic [((NUM_CLK_EN > 1) ? $clog2(NUM_CLK_EN) : 1)-1:0] cur_ch
);

   localparam int CH_W = (NUM_CLK_EN > 1) ? $clog2(NUM_CLK_EN) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                state_q,  state_d;
   logic [NUM_CLK_EN-1:0] clk_en_q, clk_en_d;
   logic [NUM_CLK_EN-1:0] ack_q,    ack_d;
   logic                  busy_q,   busy_d;
   logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
   logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [SETTLE_W-1:0]   cnt_q,    cnt_d;

   logic [NUM_CLK_EN-1:0] pending;
   logic                  found;
   logic [CH_W-1:0]       sel;
   logic [CH_W-1:0]       rr_next;

   assign pending = req_en ^ clk_en_q;

   // First pending channel at or above rr_ptr, wrapping modulo NUM_CLK_EN.
   always_comb begin : pick_channel
      int              idx;
      logic [CH_W-1:0] cand;
      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      cand  = '0;
      for (int k = 0; k < NUM_CLK_EN; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_CLK_EN) idx = idx - NUM_CLK_EN;
         cand = CH_W'(idx);
         if (!found && (|(pending & (NUM_CLK_EN'(1) << cand)))) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin : next_rr
      int nxt;
      nxt     = int'(cur_ch_q) + 1;
      rr_next = (nxt >= NUM_CLK_EN) ? '0 : CH_W'(nxt);
   end

   always_comb begin : next_state
      state_d  = state_q;
      clk_en_d = clk_en_q;
      ack_d    = '0;
      busy_d   = busy_q;
      cur_ch_d = cur_ch_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               clk_en_d = clk_en_q ^ (NUM_CLK_EN'(1) << sel);
               cur_ch_d = sel;
               busy_d   = 1'b1;
               cnt_d    = settle_cycles;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            // Count is only reloaded in IDLE, so settle_cycles edits here have no effect.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - SETTLE_W'(1);
            end else begin
               ack_d   = NUM_CLK_EN'(1) << cur_ch_q;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d   = 1'b0;
            rr_ptr_d = rr_next;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         clk_en_q <= '0;
         ack_q    <= '0;
         busy_q   <= 1'b0;
         cur_ch_q <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         clk_en_q <= clk_en_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         cur_ch_q <= cur_ch_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign clk_en = clk_en_q;
   assign ack    = ack_q;
   assign busy   = busy_q;
   assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_clk_en_seq_ctrl.sv
// Self-checking bench for clk_en_seq_ctrl: directed vector table, corner-case sequences
// and randomized traffic compared against a timeline-based reference model.
module tb_clk_en_seq_ctrl;

   localparam int N = 4;

   logic       clk;
   logic       rst;
   logic [3:0] req_en;
   logic [7:0] settle_cycles;
   logic [3:0] clk_en;
   logic [3:0] ack;
   logic       busy;
   logic [1:0] cur_ch;

   logic [3:0] req4;
   logic [3:0] s4;
   logic [3:0] clk_en4;
   logic [3:0] ack4;
   logic       busy4;
   logic [1:0] cur4;

   clk_en_seq_ctrl #(.NUM_CLK_EN(4), .SETTLE_W(8)) u_dut (
      .clk(clk), .rst(rst), .req_en(req_en), .settle_cycles(settle_cycles),
      .clk_en(clk_en), .ack(ack), .busy(busy), .cur_ch(cur_ch)
   );

   clk_en_seq_ctrl #(.NUM_CLK_EN(4), .SETTLE_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .req_en(req4), .settle_cycles(s4),
      .clk_en(clk_en4), .ack(ack4), .busy(busy4), .cur_ch(cur4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each change is a timeline anchored at its selection edge t
   // with settle s; busy covers cycles t+1..t+2+s, ack is cycle t+2+s.
   int         m_e, m_t, m_s, m_ch, m_rr;
   bit         m_active;
   logic [3:0] m_clk_en;
   logic [3:0] exp_clk_en, exp_ack;
   logic       exp_busy;
   logic [1:0] exp_cur;

   task automatic model_reset();
      m_e = 0; m_t = 0; m_s = 0; m_ch = 0; m_rr = 0;
      m_active = 0; m_clk_en = '0;
   endtask

   task automatic model_edge();
      int  e = m_e;
      bit  hit = 0;
      int  idx;
      if (m_active && e == m_t + 2 + m_s) begin
         m_active = 0;
         m_rr = (m_ch + 1) % N;
      end else if (!m_active) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (!hit && (req_en[idx] != m_clk_en[idx])) begin
               hit = 1;
               m_active = 1;
               m_t = e;
               m_s = int'(settle_cycles);
               m_ch = idx;
               m_clk_en[idx] = ~m_clk_en[idx];
            end
         end
      end
      exp_busy   = m_active;
      exp_ack    = (m_active && (e + 1 == m_t + 2 + m_s)) ? 4'(1 << m_ch) : 4'h0;
      exp_clk_en = m_clk_en;
      exp_cur    = 2'(m_ch);
      m_e++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("clk_en", clk_en, exp_clk_en);
      check("ack", ack, exp_ack);
      check("busy", busy, exp_busy);
      check("cur_ch", cur_ch, exp_cur);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_en = '0;
      req4 = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   function automatic int bit_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   typedef struct {
      logic [3:0] req;
      logic [7:0] settle;
      logic [3:0] exp_clk_en;
      logic [3:0] exp_ack;
      logic       exp_busy;
      logic [1:0] exp_cur;
   } vec_t;

   vec_t vecs[9];
   int   ack_q[$];
   int   hit_j;

   initial begin
      // Single change on channel 2 with settle 5; settle edited mid-SETTLE at entry 3.
      vecs[0] = '{4'b0100, 8'd5, 4'b0100, 4'b0000, 1'b1, 2'd2};
      for (int i = 1; i <= 5; i++) vecs[i] = '{4'b0100, 8'd5, 4'b0100, 4'b0000, 1'b1, 2'd2};
      vecs[3].settle = 8'd9;
      vecs[6] = '{4'b0100, 8'd5, 4'b0100, 4'b0100, 1'b1, 2'd2};
      vecs[7] = '{4'b0100, 8'd5, 4'b0100, 4'b0000, 1'b0, 2'd2};
      vecs[8] = '{4'b0100, 8'd5, 4'b0100, 4'b0000, 1'b0, 2'd2};

      rst = 1'b1;
      req_en = '0;
      settle_cycles = '0;
      req4 = '0;
      s4 = '0;
      #1;
      check("rst_clk_en", clk_en, 4'h0);
      check("rst_ack", ack, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_cur_ch", cur_ch, 2'd0);

      do_reset();
      for (int i = 0; i < 9; i++) begin
         req_en = vecs[i].req;
         settle_cycles = vecs[i].settle;
         tick();
         check("vec_clk_en", clk_en, vecs[i].exp_clk_en);
         check("vec_ack", ack, vecs[i].exp_ack);
         check("vec_busy", busy, vecs[i].exp_busy);
         check("vec_cur_ch", cur_ch, vecs[i].exp_cur);
      end

      // Round-robin set then clear, settle 0.
      do_reset();
      settle_cycles = 8'd0;
      req_en = 4'b1111;
      ack_q.delete();
      for (int j = 0; j < 14; j++) begin
         tick();
         if (ack != 0) ack_q.push_back(bit_idx(ack));
      end
      check("rr_set_count", ack_q.size(), 4);
      for (int i = 0; i < 4; i++) if (i < ack_q.size()) check("rr_set_order", ack_q[i], i);
      check("rr_set_final", clk_en, 4'b1111);
      req_en = 4'b0000;
      ack_q.delete();
      for (int j = 0; j < 14; j++) begin
         tick();
         if (ack != 0) ack_q.push_back(bit_idx(ack));
      end
      check("rr_clr_count", ack_q.size(), 4);
      for (int i = 0; i < 4; i++) if (i < ack_q.size()) check("rr_clr_order", ack_q[i], i);

      // Fairness wrap: channel 3 was last, so 1 goes before 3.
      req_en = 4'b1010;
      ack_q.delete();
      for (int j = 0; j < 10; j++) begin
         tick();
         if (ack != 0) ack_q.push_back(bit_idx(ack));
      end
      check("wrap_count", ack_q.size(), 2);
      if (ack_q.size() == 2) begin
         check("wrap_first", ack_q[0], 1);
         check("wrap_second", ack_q[1], 3);
      end

      // Revert during settle.
      do_reset();
      settle_cycles = 8'd10;
      req_en = 4'b0001;
      tick();
      check("revert_rise", clk_en[0], 1'b1);
      tick();
      req_en = 4'b0000;
      hit_j = -1;
      for (int j = 2; j <= 20; j++) begin
         tick();
         if (ack[0] && hit_j < 0) hit_j = j;
      end
      check("revert_ack_cycle", hit_j, 11);
      hit_j = -1;
      for (int j = 0; j < 30; j++) begin
         tick();
         if (ack[0] && hit_j < 0) begin
            hit_j = j;
            check("revert_fall", clk_en[0], 1'b0);
         end
      end
      check("revert_second_ack_seen", hit_j >= 0, 1'b1);

      // Asynchronous reset in the middle of SETTLE.
      do_reset();
      settle_cycles = 8'd10;
      req_en = 4'b0010;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      check("arst_clk_en", clk_en, 4'h0);
      check("arst_ack", ack, 4'h0);
      check("arst_busy", busy, 1'b0);
      check("arst_cur_ch", cur_ch, 2'd0);
      for (int j = 0; j < 3; j++) begin
         @(posedge clk);
         #1;
         check("arst_hold_ack", ack, 4'h0);
         check("arst_hold_clk_en", clk_en, 4'h0);
      end
      rst = 1'b0;
      model_reset();
      tick();
      check("arst_resume", clk_en, 4'b0010);
      repeat (15) tick();

      // Maximum settle on a 4-bit counter instance.
      do_reset();
      s4 = 4'd15;
      req4 = 4'b0001;
      tick();
      check("max_rise", clk_en4, 4'b0001);
      for (int j = 1; j <= 17; j++) begin
         tick();
         check("max_ack", ack4, (j == 16) ? 4'b0001 : 4'b0000);
         check("max_busy", busy4, (j <= 16) ? 1'b1 : 1'b0);
      end

      // Randomized traffic against the model.
      do_reset();
      for (int j = 0; j < 1500; j++) begin
         if ($urandom_range(0, 3) == 0) req_en = req_en ^ 4'(1 << $urandom_range(0, 3));
         settle_cycles = 8'($urandom_range(0, 6));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
